arm_alu_mc: RTL and testbench
=============================

Name: arm_alu_mc

Overview:
Parametrised, multi-cycle successor to the single-cycle ARM data-processing ALU.
- Executes all 16 data-processing opcodes with a registered result, one cycle of latency.
- Adds the ARM multiply family (MUL, MLA, UMULL, UMLAL, SMULL, SMLAL) on an iterative shift-add datapath.
- Sits between the operand/shifter stage and register-file writeback.
- Uses a valid/ready handshake on both sides so the control FSM can stall on long multiplies.

Parameters:
WIDTH, 32, operand/result word width; must be even and ≥8.
MUL_BITS, 2, multiplier bits retired per iteration; must divide WIDTH (1, 2, 4).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operation offered
in_ready  out  1  block can accept (state IDLE)
op_sel  in  4  data-processing opcode (instruction[24:21] encoding); ignored when mul_en=1
mul_en  in  1  select multiply family
mul_long  in  1  64-bit (2·WIDTH) product
mul_signed  in  1  signed long multiply (SMULL/SMLAL)
mul_acc  in  1  accumulate (MLA/UMLAL/SMLAL)
op1  in  WIDTH  Rn, or Rm for multiply
op2  in  WIDTH  shifter_operand, or Rs for multiply
acc_lo  in  WIDTH  accumulator low (Rn for MLA, RdLo for long)
acc_hi  in  WIDTH  accumulator high (RdHi); long only
shc_in  in  1  shifter carry-out
flags_in  in  4  {N,Z,C,V} from CPSR
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result_lo  out  WIDTH  result / product low
result_hi  out  WIDTH  product high; 0 when not long
flags_out  out  4  next {N,Z,C,V}
busy  out  1  state != IDLE

Behaviour:
- **Reset (async, rst=1):**
  - State IDLE.
  - result_lo, result_hi, flags_out and out_valid are all 0; in_ready=1.
  - Reset mid-operation abandons the operation with no output.
- **Handshake:**
  - Acceptance occurs when in_valid & in_ready at a rising edge; all inputs, including flags_in and shc_in, are captured at that edge.
  - Output transfer occurs when out_valid & out_ready.
  - in_ready=0 whenever state != IDLE, so no new operation is accepted while a result is pending.
- **FSM states:**
  - IDLE → DONE on a data-processing acceptance.
  - IDLE → ITER on a multiply acceptance.
  - ITER → FIX after WIDTH/MUL_BITS iterations.
  - FIX → DONE.
  - DONE → IDLE on out_ready.
  - out_valid = (state==DONE).
- **Latency (acceptance edge to out_valid high):**
  - Data-processing: 1 cycle.
  - Multiply: WIDTH/MUL_BITS + 2 cycles (18 at defaults).
  - A result is held stable in DONE until out_ready; there is no bubble on the in_ready return.
- **Data-processing ops:**
  - Standard ARM semantics; arithmetic is WIDTH+1 bits, with C=carry for add and C=~borrow for subtract.
  - V = signed overflow of the WIDTH-bit operation.
  - SBC/RSC subtract ~C_in. ADC adds C_in.
  - Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN) set C=shc_in and preserve V.
  - N = result MSB; Z = (result==0).
  - result_hi = 0.
  - TST/TEQ/CMP/CMN produce result_lo as computed; writeback suppression is the decoder's job.
- **Multiply:**
  - ITER: a 2·WIDTH accumulator is built from magnitudes; MUL_BITS multiplier bits are retired per cycle.
  - FIX (signed only):
    - Product is negated if operand signs differ.
    - Accumulator is added: acc_lo for short, {acc_hi, acc_lo} for long.
    - Sum is modulo 2^WIDTH (short) or 2^(2·WIDTH) (long).
  - Short forms return the low WIDTH bits; result_hi = 0.
  - mul_signed with mul_long=0 is treated as unsigned; the low bits are identical.
  - N and Z are taken from the full result (2·WIDTH bits when long); C and V are preserved from flags_in.
- **Boundaries:**
  - Operand 0 still takes full latency.
  - Most-negative × most-negative (signed): magnitude 2^(2W-2) is correct with no overflow.
  - Accumulate wrap-around is silently modulo.

Decomposition:
- Package arm_alu_pkg holds:
  - Opcode constants AND…MVN (0000…1111).
  - Flag index constants N=3, Z=2, C=1, V=0.
  - FSM state enum {IDLE, ITER, FIX, DONE}.
- Sub-module arm_mul_iter: sequential magnitude multiplier with start/done, parametrised WIDTH and MUL_BITS.
- arm_alu_mc owns the FSM, the data-processing path, sign fix-up and accumulate.

Test Plan:
1. ADD op1=0xFFFFFFFF, op2=0x1, flags_in=0000 → result_lo=0, flags_out=0110, out_valid exactly 1 cycle after acceptance.
2. SUB op1=0x80000000, op2=0x1 → result_lo=0x7FFFFFFF, flags_out=0011; SBC same operands with C_in=0 → 0x7FFFFFFE, flags_out=0011.
3. SMULL op1=0xFFFFFFFE, op2=0x3, flags_in=0011 → result_hi=0xFFFFFFFF, result_lo=0xFFFFFFFA, flags_out=1011, out_valid at cycle 18.
4. UMLAL op1=op2=0xFFFFFFFF, acc_hi=acc_lo=0x1 → result_hi=0xFFFFFFFF, result_lo=0x00000002, N=1, Z=0.
5. Back-pressure: out_ready low 5 cycles after a MOV 0x0 with shc_in=1 → result and flags_out=0110 held, in_ready=0, and a concurrent in_valid is not accepted.
6. Reset asserted at cycle 7 of a MUL, then ADD 2+3 → all outputs 0 during reset; ADD returns 0x5 with flags_out=0000.
7. WIDTH=8, MUL_BITS=4, MUL 0x0F×0x11 → result_lo=0xFF, N=1, latency 4.

Source files
------------

// File: rtl/arm_alu_pkg.sv
// Shared opcode encodings, CPSR flag bit positions and control FSM states
// for the multi-cycle ARM data-processing / multiply ALU.
package arm_alu_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/arm_mul_iter.sv
// Iterative unsigned shift-add multiplier: retires MUL_BITS multiplier bits
// per cycle, WIDTH/MUL_BITS cycles after a start pulse.
module arm_mul_iter #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_mcand,
  input  logic [WIDTH-1:0]     i_mplier,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_prod
);

  localparam int STEPS = WIDTH / MUL_BITS;
  localparam int CW    = $clog2(STEPS + 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] w_partial;

  assign w_partial = r_mcand * {{(2*WIDTH-MUL_BITS){1'b0}}, r_mplier[MUL_BITS-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_mcand};
      r_mplier <= i_mplier;
      r_prod   <= '0;
      r_cnt    <= CW'(STEPS);
    end else if (r_cnt != '0) begin
      r_prod   <= r_prod + w_partial;
      r_mcand  <= r_mcand << MUL_BITS;
      r_mplier <= r_mplier >> MUL_BITS;
      r_cnt    <= r_cnt - CW'(1);
    end
  end

  // High during the cycle whose closing edge retires the last digit, so the
  // controller can leave ITER on that same edge.
  assign o_done = (r_cnt == CW'(1));
  assign o_prod = r_prod;

endmodule

// File: rtl/arm_alu_mc.sv
// Multi-cycle ARM ALU: registered data-processing ops plus the MUL/MLA/long
// multiply family, with valid/ready handshakes on input and output.
module arm_alu_mc
  import arm_alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_sel,
  input  logic             mul_en,
  input  logic             mul_long,
  input  logic             mul_signed,
  input  logic             mul_acc,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic             shc_in,
  input  logic [3:0]       flags_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags_out,
  output logic             busy
);

  // Handshake: an operation transfers on a rising edge with in_valid & in_ready,
  // a result on a rising edge with out_valid & out_ready; in_ready only in IDLE.
  state_t             r_state;
  logic [WIDTH-1:0]   r_result_lo;
  logic [WIDTH-1:0]   r_result_hi;
  logic [3:0]         r_flags;
  logic               r_mul_neg;
  logic               r_mul_long;
  logic               r_mul_acc;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [3:0]         r_flags_in;

  logic               w_accept;
  logic               w_mul_start;
  logic               w_mul_sgn;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_acc_full;
  logic [2*WIDTH-1:0] w_mul_sum;
  logic [3:0]         w_mul_flags;

  logic [WIDTH-1:0]   w_x;
  logic [WIDTH-1:0]   w_y;
  logic               w_cin;
  logic               w_arith;
  logic [WIDTH-1:0]   w_logic;
  logic [WIDTH:0]     w_dp_sum;
  logic [WIDTH-1:0]   w_dp_res;
  logic [3:0]         w_dp_flags;

  assign w_accept    = in_valid && (r_state == IDLE);
  assign w_mul_start = w_accept && mul_en;

  // Signed arithmetic only exists for the long forms; short forms share low bits.
  assign w_mul_sgn = mul_signed && mul_long;
  assign w_mag1    = (w_mul_sgn && op1[WIDTH-1]) ? -op1 : op1;
  assign w_mag2    = (w_mul_sgn && op2[WIDTH-1]) ? -op2 : op2;

  arm_mul_iter #(
    .WIDTH    (WIDTH),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_mul_start),
    .i_mcand  (w_mag1),
    .i_mplier (w_mag2),
    .o_done   (w_mul_done),
    .o_prod   (w_prod)
  );

  assign w_prod_s   = r_mul_neg ? -w_prod : w_prod;
  assign w_acc_full = !r_mul_acc ? '0 :
                      r_mul_long ? {r_acc_hi, r_acc_lo} : {{WIDTH{1'b0}}, r_acc_lo};
  assign w_mul_sum  = w_prod_s + w_acc_full;

  always_comb begin
    w_mul_flags         = r_flags_in;
    w_mul_flags[FLAG_N] = r_mul_long ? w_mul_sum[2*WIDTH-1] : w_mul_sum[WIDTH-1];
    w_mul_flags[FLAG_Z] = r_mul_long ? (w_mul_sum == '0) : (w_mul_sum[WIDTH-1:0] == '0);
  end

  // Every arithmetic op is x + y + cin with subtraction as x + ~y + cin.
  always_comb begin
    w_x     = op1;
    w_y     = op2;
    w_cin   = 1'b0;
    w_arith = 1'b1;
    w_logic = '0;
    case (op_sel)
      OP_AND, OP_TST: begin w_arith = 1'b0; w_logic = op1 & op2;  end
      OP_EOR, OP_TEQ: begin w_arith = 1'b0; w_logic = op1 ^ op2;  end
      OP_ORR:         begin w_arith = 1'b0; w_logic = op1 | op2;  end
      OP_MOV:         begin w_arith = 1'b0; w_logic = op2;        end
      OP_BIC:         begin w_arith = 1'b0; w_logic = op1 & ~op2; end
      OP_MVN:         begin w_arith = 1'b0; w_logic = ~op2;       end
      OP_SUB, OP_CMP: begin w_y = ~op2; w_cin = 1'b1; end
      OP_RSB:         begin w_x = op2; w_y = ~op1; w_cin = 1'b1; end
      OP_ADC:         begin w_cin = flags_in[FLAG_C]; end
      OP_SBC:         begin w_y = ~op2; w_cin = flags_in[FLAG_C]; end
      OP_RSC:         begin w_x = op2; w_y = ~op1; w_cin = flags_in[FLAG_C]; end
      default:        ;
    endcase
  end

  assign w_dp_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
  assign w_dp_res = w_arith ? w_dp_sum[WIDTH-1:0] : w_logic;

  always_comb begin
    w_dp_flags         = flags_in;
    w_dp_flags[FLAG_N] = w_dp_res[WIDTH-1];
    w_dp_flags[FLAG_Z] = (w_dp_res == '0);
    w_dp_flags[FLAG_C] = w_arith ? w_dp_sum[WIDTH] : shc_in;
    if (w_arith) begin
      w_dp_flags[FLAG_V] = (w_x[WIDTH-1] == w_y[WIDTH-1]) &&
                           (w_dp_sum[WIDTH-1] != w_x[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_result_lo <= '0;
      r_result_hi <= '0;
      r_flags     <= '0;
      r_mul_neg   <= 1'b0;
      r_mul_long  <= 1'b0;
      r_mul_acc   <= 1'b0;
      r_acc_lo    <= '0;
      r_acc_hi    <= '0;
      r_flags_in  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (mul_en) begin
              r_state    <= ITER;
              r_mul_neg  <= w_mul_sgn && (op1[WIDTH-1] ^ op2[WIDTH-1]);
              r_mul_long <= mul_long;
              r_mul_acc  <= mul_acc;
              r_acc_lo   <= acc_lo;
              r_acc_hi   <= acc_hi;
              r_flags_in <= flags_in;
            end else begin
              r_state     <= DONE;
              r_result_lo <= w_dp_res;
              r_result_hi <= '0;
              r_flags     <= w_dp_flags;
            end
          end
        end
        ITER: begin
          if (w_mul_done) r_state <= FIX;
        end
        FIX: begin
          r_state     <= DONE;
          r_result_lo <= w_mul_sum[WIDTH-1:0];
          r_result_hi <= r_mul_long ? w_mul_sum[2*WIDTH-1:WIDTH] : '0;
          r_flags     <= w_mul_flags;
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign result_lo = r_result_lo;
  assign result_hi = r_result_hi;
  assign flags_out = r_flags;

endmodule

// File: tb/tb_arm_alu_mc.sv
// Directed bench for arm_alu_mc: default 32/2 instance plus an 8/4 instance,
// hand-computed results, flags and latencies.
module tb_arm_alu_mc;
  import arm_alu_pkg::*;

  logic        clk;
  logic        rst;
  int          n_checks;
  int          n_fail;

  // Default-parameter DUT
  logic        in_valid, in_ready, mul_en, mul_long, mul_signed, mul_acc;
  logic [3:0]  op_sel, flags_in, flags_out;
  logic [31:0] op1, op2, acc_lo, acc_hi, result_lo, result_hi;
  logic        shc_in, out_valid, out_ready, busy;

  // WIDTH=8, MUL_BITS=4 DUT
  logic        in_valid_8, in_ready_8, mul_en_8, out_valid_8, out_ready_8, busy_8;
  logic [3:0]  op_sel_8, flags_in_8, flags_out_8;
  logic [7:0]  op1_8, op2_8, result_lo_8, result_hi_8;

  arm_alu_mc #(.WIDTH(32), .MUL_BITS(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel),
    .mul_en(mul_en), .mul_long(mul_long), .mul_signed(mul_signed), .mul_acc(mul_acc),
    .op1(op1), .op2(op2), .acc_lo(acc_lo), .acc_hi(acc_hi), .shc_in(shc_in),
    .flags_in(flags_in), .out_valid(out_valid), .out_ready(out_ready),
    .result_lo(result_lo), .result_hi(result_hi), .flags_out(flags_out), .busy(busy)
  );

  arm_alu_mc #(.WIDTH(8), .MUL_BITS(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8), .op_sel(op_sel_8),
    .mul_en(mul_en_8), .mul_long(1'b0), .mul_signed(1'b0), .mul_acc(1'b0),
    .op1(op1_8), .op2(op2_8), .acc_lo(8'h00), .acc_hi(8'h00), .shc_in(1'b0),
    .flags_in(flags_in_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
    .result_lo(result_lo_8), .result_hi(result_hi_8), .flags_out(flags_out_8), .busy(busy_8)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Driver: offers one operation (called at posedge+1), measures latency in
  // edges from acceptance, checks outputs, optionally holds out_ready low
  // while offering a competing ADD, then takes the result.
  task automatic run_op(input string tag, input logic [3:0] op, input logic m_en,
                        input logic m_long, input logic m_sgn, input logic m_acc,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] alo, input logic [31:0] ahi,
                        input logic shc, input logic [3:0] fl,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input logic [3:0] exp_fl, input int exp_lat, input int hold);
    int lat;
    check_eq({tag, "/in_ready"}, {63'd0, in_ready}, 64'd1);
    op_sel = op; mul_en = m_en; mul_long = m_long; mul_signed = m_sgn; mul_acc = m_acc;
    op1 = a; op2 = b; acc_lo = alo; acc_hi = ahi; shc_in = shc; flags_in = fl;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op1 = $urandom; op2 = $urandom; flags_in = 4'($urandom_range(0, 15)); shc_in = ~shc;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "/result_lo"}, {32'd0, result_lo}, {32'd0, exp_lo});
    check_eq({tag, "/result_hi"}, {32'd0, result_hi}, {32'd0, exp_hi});
    check_eq({tag, "/flags_out"}, {60'd0, flags_out}, {60'd0, exp_fl});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; mul_en = 1'b0; op_sel = OP_ADD; op1 = 32'd1; op2 = 32'd1;
      @(posedge clk); #1;
      check_eq({tag, "/hold_in_ready"}, {63'd0, in_ready}, 64'd0);
      check_eq({tag, "/hold_valid"}, {63'd0, out_valid}, 64'd1);
      check_eq({tag, "/hold_lo"}, {32'd0, result_lo}, {32'd0, exp_lo});
      check_eq({tag, "/hold_flags"}, {60'd0, flags_out}, {60'd0, exp_fl});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "/post_valid"}, {63'd0, out_valid}, 64'd0);
    check_eq({tag, "/post_in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    int lat;
    n_checks = 0; n_fail = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_sel = '0; mul_en = 1'b0;
    mul_long = 1'b0; mul_signed = 1'b0; mul_acc = 1'b0; op1 = '0; op2 = '0;
    acc_lo = '0; acc_hi = '0; shc_in = 1'b0; flags_in = '0;
    in_valid_8 = 1'b0; out_ready_8 = 1'b0; op_sel_8 = '0; mul_en_8 = 1'b0;
    op1_8 = '0; op2_8 = '0; flags_in_8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset/result_lo", {32'd0, result_lo}, 64'd0);
    check_eq("reset/result_hi", {32'd0, result_hi}, 64'd0);
    check_eq("reset/flags_out", {60'd0, flags_out}, 64'd0);
    check_eq("reset/out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("reset/in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("reset/busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    //        tag          op      en   lg   sg   ac   op1           op2           acc_lo        acc_hi        shc  fl       exp_lo        exp_hi        exp_fl   lat hold
    run_op("add_wrap",  OP_ADD, 1'b0,1'b0,1'b0,1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        1'b0,4'b0000,32'h00000000,32'h0,        4'b0110, 1, 0);
    run_op("sub_ovf",   OP_SUB, 1'b0,1'b0,1'b0,1'b0, 32'h80000000, 32'h00000001, 32'h0,        32'h0,        1'b0,4'b0000,32'h7FFFFFFF,32'h0,        4'b0011, 1, 0);
    run_op("sbc_c0",    OP_SBC, 1'b0,1'b0,1'b0,1'b0, 32'h80000000, 32'h00000001, 32'h0,        32'h0,        1'b0,4'b0000,32'h7FFFFFFE,32'h0,        4'b0011, 1, 0);
    run_op("rsb_neg",   OP_RSB, 1'b0,1'b0,1'b0,1'b0, 32'h00000005, 32'h00000003, 32'h0,        32'h0,        1'b0,4'b0000,32'hFFFFFFFE,32'h0,        4'b1000, 1, 0);
    run_op("rsc_c1",    OP_RSC, 1'b0,1'b0,1'b0,1'b0, 32'h00000001, 32'h00000000, 32'h0,        32'h0,        1'b0,4'b0010,32'hFFFFFFFF,32'h0,        4'b1000, 1, 0);
    run_op("adc_ovf",   OP_ADC, 1'b0,1'b0,1'b0,1'b0, 32'h7FFFFFFF, 32'h00000000, 32'h0,        32'h0,        1'b0,4'b0010,32'h80000000,32'h0,        4'b1001, 1, 0);
    run_op("bic_keepv", OP_BIC, 1'b0,1'b0,1'b0,1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0,        32'h0,        1'b0,4'b0001,32'hF000F000,32'h0,        4'b1001, 1, 0);
    run_op("teq_zero",  OP_TEQ, 1'b0,1'b0,1'b0,1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'h0,        1'b0,4'b0011,32'h00000000,32'h0,        4'b0101, 1, 0);
    run_op("smull",     OP_AND, 1'b1,1'b1,1'b1,1'b0, 32'hFFFFFFFE, 32'h00000003, 32'h0,        32'h0,        1'b0,4'b0011,32'hFFFFFFFA,32'hFFFFFFFF, 4'b1011,18, 0);
    run_op("umlal",     OP_AND, 1'b1,1'b1,1'b0,1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0,4'b0000,32'h00000002,32'hFFFFFFFF, 4'b1000,18, 0);
    run_op("smull_mn",  OP_AND, 1'b1,1'b1,1'b1,1'b0, 32'h80000000, 32'h80000000, 32'h0,        32'h0,        1'b0,4'b0000,32'h00000000,32'h40000000, 4'b0000,18, 0);
    run_op("mla_wrap",  OP_AND, 1'b1,1'b0,1'b0,1'b1, 32'h00000003, 32'h00000004, 32'hFFFFFFFF, 32'h12345678, 1'b0,4'b0000,32'h0000000B,32'h0,        4'b0000,18, 0);
    run_op("mul_zero",  OP_AND, 1'b1,1'b0,1'b1,1'b0, 32'h00000000, 32'h00001234, 32'h0,        32'h0,        1'b0,4'b1101,32'h00000000,32'h0,        4'b0101,18, 0);

    // Reset in the middle of a multiply abandons it
    op_sel = OP_AND; mul_en = 1'b1; mul_long = 1'b1; mul_signed = 1'b0; mul_acc = 1'b0;
    op1 = 32'h00000005; op2 = 32'h00000007; flags_in = 4'b0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check_eq("midrst/busy_before", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check_eq("midrst/result_lo", {32'd0, result_lo}, 64'd0);
    check_eq("midrst/result_hi", {32'd0, result_hi}, 64'd0);
    check_eq("midrst/flags_out", {60'd0, flags_out}, 64'd0);
    check_eq("midrst/out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("midrst/busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      check_eq("midrst/no_output", {63'd0, out_valid}, 64'd0);
    end
    run_op("add_after", OP_ADD, 1'b0,1'b0,1'b0,1'b0, 32'h00000002, 32'h00000003, 32'h0,        32'h0,        1'b0,4'b0000,32'h00000005,32'h0,        4'b0000, 1, 0);

    // Back-pressure: MOV 0 held for 5 cycles with a competing request
    run_op("mov_hold",  OP_MOV, 1'b0,1'b0,1'b0,1'b0, 32'h12345678, 32'h00000000, 32'h0,        32'h0,        1'b1,4'b0000,32'h00000000,32'h0,        4'b0110, 1, 5);

    // WIDTH=8, MUL_BITS=4: MUL 0x0F x 0x11
    check_eq("w8/in_ready", {63'd0, in_ready_8}, 64'd1);
    op_sel_8 = OP_AND; mul_en_8 = 1'b1; op1_8 = 8'h0F; op2_8 = 8'h11; flags_in_8 = 4'b0000;
    in_valid_8 = 1'b1;
    @(posedge clk); #1;
    in_valid_8 = 1'b0;
    lat = 1;
    while (!out_valid_8 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("w8/latency", 64'(lat), 64'd4);
    check_eq("w8/result_lo", {56'd0, result_lo_8}, 64'hFF);
    check_eq("w8/result_hi", {56'd0, result_hi_8}, 64'h00);
    check_eq("w8/flags_out", {60'd0, flags_out_8}, {60'd0, 4'b1000});
    check_eq("w8/busy", {63'd0, busy_8}, 64'd1);
    out_ready_8 = 1'b1;
    @(posedge clk); #1;
    out_ready_8 = 1'b0;
    check_eq("w8/post_in_ready", {63'd0, in_ready_8}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
